calib_param_bank: RTL and testbench
===================================

Name: calib_param_bank

Overview:
- Parametrised per-channel gain/offset calibration bank for the MPS ADC conversion path. It replaces the fixed gain/offset constant sources.
- Software writes IEEE-754 single-precision gain/offset words into shadow registers.
- A commit request transfers all shadow words to the active set atomically, on the next ADC frame boundary.
- Active values drive the per-channel float multiply/add stages. Each commit is also broadcast as an AXIS burst, one beat per channel.

Parameters:
- NUM_CH, 20, number of calibrated channels (2..64).
- DEFAULT_GAIN, 32'h35A0_0000, reset/restore gain (1.1920928955078125e-6).
- DEFAULT_OFFSET, 32'hC120_0000, reset/restore offset (-10.0).
- CH_W, $clog2(NUM_CH), channel index width.
- ADDR_W, $clog2(2*NUM_CH+1), word address width.

Ports:
- s00_axi_aclk  in  1  single clock for the whole block.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  shadow write strobe.
- i_wr_addr  in  ADDR_W  word address. 0..NUM_CH-1 is gain[ch]; NUM_CH..2*NUM_CH-1 is offset[ch].
- i_wr_data  in  32  write data.
- i_rd_addr  in  ADDR_W  read address, same map. Address 2*NUM_CH returns status.
- o_rd_data  out  32  registered read data.
- i_commit  in  1  commit request pulse.
- i_defaults  in  1  load defaults into the shadow set.
- i_frame_sync  in  1  ADC frame boundary pulse.
- o_gain  out  NUM_CH*32  active gains; channel n occupies bits [32n+31:32n].
- o_offset  out  NUM_CH*32  active offsets, same packing.
- m_axis_tdata  out  64  {offset, gain} for channel m_axis_tuser.
- m_axis_tuser  out  CH_W  channel index.
- m_axis_tlast  out  1  high on the channel NUM_CH-1 beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- o_commit_pending  out  1  a commit is requested but not yet applied.
- o_version  out  16  commit counter.

Behaviour:
- Reset (asynchronous, active-high) values:
  - shadow and active gain = DEFAULT_GAIN; shadow and active offset = DEFAULT_OFFSET.
  - o_version = 0, o_rd_data = 0, m_axis_tvalid = 0, m_axis_tuser = 0, m_axis_tlast = 0, o_commit_pending = 0.
  - State = IDLE.
- Reset asserted mid-burst aborts the burst: tvalid drops at once, all state returns to reset values.
- Shadow writes:
  - Accepted in every state, one cycle.
  - Addresses >= 2*NUM_CH are ignored.
  - i_defaults reloads all shadow words. If i_wr_en is high in the same cycle, the addressed word takes i_wr_data; all other words take defaults.
  - Active registers are never written directly by software.
- Reads:
  - o_rd_data is registered, valid 1 cycle after i_rd_addr.
  - Address < 2*NUM_CH returns the shadow word.
  - Address 2*NUM_CH returns status: {o_version[15:0], 13'b0, pend, state[1:0]}.
  - Any other address returns 0.
- FSM states are IDLE, ARMED and STREAM.
  - IDLE: i_commit moves to ARMED and sets o_commit_pending. A frame_sync in the same cycle as i_commit does not apply the commit.
  - ARMED: on i_frame_sync, all active <= shadow in one cycle and o_version increments (wraps 16'hFFFF -> 0). o_commit_pending clears, m_axis_tuser = 0, and the FSM moves to STREAM. The first beat's tvalid is high in the cycle after the frame_sync.
  - ARMED: a repeated i_commit has no effect. Shadow writes made before the applying frame_sync are included in the commit.
  - STREAM: tvalid is held high. tdata = {active offset[tuser], active gain[tuser]}. tdata/tuser/tlast stay stable while tready is low.
  - STREAM: each handshake (tvalid & tready) advances tuser. The handshake on tlast returns to IDLE, with tvalid low the next cycle. If a commit is pending at that point, the FSM goes to ARMED instead.
  - STREAM: i_commit sets o_commit_pending (deferred). i_frame_sync is ignored. Active values cannot change during a burst.
- Arithmetic:
  - No float arithmetic inside the block; values are opaque 32-bit words.
  - Channel counter is CH_W bits and never exceeds NUM_CH-1.

Decomposition:
- Shared package calib_pkg holds:
  - state enum {IDLE, ARMED, STREAM};
  - DEFAULT_GAIN and DEFAULT_OFFSET constants;
  - status-word bit positions;
  - the address-map helper constants.
- One sub-module, calib_axis_burst: channel counter, tvalid/tlast generation and handshake hold. It takes start and returns done.
- Register arrays and FSM stay in the top.

Test Plan (NUM_CH=4):
- Reset and release -> o_gain lanes all 32'h35A00000, o_offset lanes all 32'hC1200000, version 0, tvalid 0.
- Write gain[2]=32'h3F800000, then i_commit, then frame_sync 5 cycles later:
  - o_gain lane 2 changes only in the cycle after frame_sync; version = 1;
  - 4 beats with tuser 0..3; beat 2 tdata = {C1200000, 3F800000}; tlast on beat 3.
- Hold tready low for 3 cycles during beat 1 -> tdata/tuser/tlast held; exactly 4 beats total.
- i_commit during STREAM with shadow changed -> pending=1; after tlast FSM is ARMED; next frame_sync applies it; version = 2.
- i_commit and frame_sync in the same cycle in IDLE -> no change to active; applied at the next frame_sync.
- i_defaults with i_wr_en to offset[1]=32'h0 -> shadow offset[1]=0 and others default; read of address 8 returns the status word; read of address 9 returns 0; reset asserted mid-burst -> tvalid 0 immediately.

Source files
------------

// File: rtl/calib_pkg.sv
// Shared types and constants for the calibration parameter bank:
// FSM state encoding, reset/restore words, status-word layout and address map.
package calib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_GAIN   = 32'h35A0_0000;
    localparam logic [31:0] DEFAULT_OFFSET = 32'hC120_0000;

    // Status word: {version[15:0], 13'b0, pend, state[1:0]}
    localparam int ST_STATE_LSB = 0;
    localparam int ST_PEND_BIT  = 2;
    localparam int ST_VER_LSB   = 16;

    function automatic int offset_base(input int num_ch);
        return num_ch;
    endfunction

    function automatic int status_addr(input int num_ch);
        return 2 * num_ch;
    endfunction

endpackage

// File: rtl/calib_axis_burst.sv
// One-beat-per-channel AXIS burst sequencer: channel counter, tvalid/tlast
// and hold-while-not-ready. A start pulse launches a burst; done marks the tlast handshake.
module calib_axis_burst #(
    parameter int NUM_CH = 20,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_tready,
    output logic            o_tvalid,
    output logic [CH_W-1:0] o_tuser,
    output logic            o_tlast,
    output logic            o_done
);

    logic            r_valid;
    logic [CH_W-1:0] r_ch;

    assign o_tvalid = r_valid;
    assign o_tuser  = r_ch;
    assign o_tlast  = r_valid && (r_ch == CH_W'(NUM_CH - 1));
    assign o_done   = r_valid && i_tready && o_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else if (i_start) begin
            r_valid <= 1'b1;
            r_ch    <= '0;
        end else if (r_valid && i_tready) begin
            if (o_tlast) begin
                r_valid <= 1'b0;
                r_ch    <= '0;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calib_param_bank.sv
// Per-channel gain/offset calibration bank: shadow set written by software,
// committed atomically to the active set on a frame boundary, then broadcast over AXIS.
module calib_param_bank #(
    parameter int          NUM_CH         = 20,
    parameter logic [31:0] DEFAULT_GAIN   = calib_pkg::DEFAULT_GAIN,
    parameter logic [31:0] DEFAULT_OFFSET = calib_pkg::DEFAULT_OFFSET,
    parameter int          CH_W           = $clog2(NUM_CH),
    parameter int          ADDR_W         = $clog2(2 * NUM_CH + 1)
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_areset,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [31:0]          i_wr_data,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [31:0]          o_rd_data,
    input  logic                 i_commit,
    input  logic                 i_defaults,
    input  logic                 i_frame_sync,
    output logic [NUM_CH*32-1:0] o_gain,
    output logic [NUM_CH*32-1:0] o_offset,
    output logic [63:0]          m_axis_tdata,
    output logic [CH_W-1:0]      m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 o_commit_pending,
    output logic [15:0]          o_version
);

    import calib_pkg::*;

    localparam int OFF_BASE  = offset_base(NUM_CH);
    localparam int STAT_ADDR = status_addr(NUM_CH);

    state_t          r_state, w_state_next;
    logic            r_pend, w_pend_next;
    logic [15:0]     r_version;
    logic [31:0]     r_rd_data, w_rd_next, w_status;
    logic [31:0]     r_sh_gain  [NUM_CH];
    logic [31:0]     r_sh_off   [NUM_CH];
    logic [31:0]     r_act_gain [NUM_CH];
    logic [31:0]     r_act_off  [NUM_CH];
    logic [NUM_CH-1:0] w_hit_gain, w_hit_off;
    logic            w_apply, w_done;

    assign w_apply = (r_state == ARMED) && i_frame_sync;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_hit_gain[gi] = i_wr_en && (i_wr_addr == ADDR_W'(gi));
            assign w_hit_off[gi]  = i_wr_en && (i_wr_addr == ADDR_W'(OFF_BASE + gi));
            assign o_gain[32*gi +: 32]   = r_act_gain[gi];
            assign o_offset[32*gi +: 32] = r_act_off[gi];
        end
    endgenerate

    // An addressed write wins over a simultaneous defaults reload for that word only.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sh_gain[i]  <= DEFAULT_GAIN;
                r_sh_off[i]   <= DEFAULT_OFFSET;
                r_act_gain[i] <= DEFAULT_GAIN;
                r_act_off[i]  <= DEFAULT_OFFSET;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit_gain[i])   r_sh_gain[i] <= i_wr_data;
                else if (i_defaults) r_sh_gain[i] <= DEFAULT_GAIN;
                if (w_hit_off[i])    r_sh_off[i]  <= i_wr_data;
                else if (i_defaults) r_sh_off[i]  <= DEFAULT_OFFSET;
                if (w_apply) begin
                    r_act_gain[i] <= r_sh_gain[i];
                    r_act_off[i]  <= r_sh_off[i];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        case (r_state)
            IDLE: begin
                if (i_commit) begin
                    w_state_next = ARMED;
                    w_pend_next  = 1'b1;
                end
            end
            ARMED: begin
                if (i_frame_sync) begin
                    w_state_next = STREAM;
                    w_pend_next  = 1'b0;
                end
            end
            STREAM: begin
                if (i_commit) w_pend_next = 1'b1;
                if (w_done)   w_state_next = w_pend_next ? ARMED : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_status = '0;
        w_status[ST_VER_LSB +: 16]  = r_version;
        w_status[ST_PEND_BIT]       = r_pend;
        w_status[ST_STATE_LSB +: 2] = r_state;
        w_rd_next = '0;
        if (i_rd_addr < ADDR_W'(OFF_BASE))
            w_rd_next = r_sh_gain[CH_W'(i_rd_addr)];
        else if (i_rd_addr < ADDR_W'(STAT_ADDR))
            w_rd_next = r_sh_off[CH_W'(i_rd_addr - ADDR_W'(OFF_BASE))];
        else if (i_rd_addr == ADDR_W'(STAT_ADDR))
            w_rd_next = w_status;
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_state   <= IDLE;
            r_pend    <= 1'b0;
            r_version <= 16'd0;
            r_rd_data <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_pend    <= w_pend_next;
            r_rd_data <= w_rd_next;
            if (w_apply) r_version <= r_version + 16'd1;
        end
    end

    calib_axis_burst #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_burst (
        .clk      (s00_axi_aclk),
        .rst      (s00_axi_areset),
        .i_start  (w_apply),
        .i_tready (m_axis_tready),
        .o_tvalid (m_axis_tvalid),
        .o_tuser  (m_axis_tuser),
        .o_tlast  (m_axis_tlast),
        .o_done   (w_done)
    );

    assign m_axis_tdata     = {r_act_off[m_axis_tuser], r_act_gain[m_axis_tuser]};
    assign o_rd_data        = r_rd_data;
    assign o_commit_pending = r_pend;
    assign o_version        = r_version;

endmodule

// File: tb/tb_calib_param_bank.sv
// Bench for calib_param_bank (NUM_CH=4): directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of shadow/active sets and beat queue.
module tb_calib_param_bank;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 4;
    localparam logic [31:0] DG = 32'h35A0_0000;
    localparam logic [31:0] DO = 32'hC120_0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic [ADDR_W-1:0]    wr_addr = '0;
    logic [31:0]          wr_data = '0;
    logic [ADDR_W-1:0]    rd_addr = '0;
    logic [31:0]          rd_data;
    logic                 commit = 1'b0;
    logic                 defaults = 1'b0;
    logic                 frame_sync = 1'b0;
    logic [NUM_CH*32-1:0] gain, offset;
    logic [63:0]          tdata;
    logic [CH_W-1:0]      tuser;
    logic                 tlast, tvalid;
    logic                 tready = 1'b1;
    logic                 pending;
    logic [15:0]          version;

    always #5 clk = ~clk;

    calib_param_bank #(.NUM_CH(NUM_CH)) dut (
        .s00_axi_aclk     (clk),
        .s00_axi_areset   (rst),
        .i_wr_en          (wr_en),
        .i_wr_addr        (wr_addr),
        .i_wr_data        (wr_data),
        .i_rd_addr        (rd_addr),
        .o_rd_data        (rd_data),
        .i_commit         (commit),
        .i_defaults       (defaults),
        .i_frame_sync     (frame_sync),
        .o_gain           (gain),
        .o_offset         (offset),
        .m_axis_tdata     (tdata),
        .m_axis_tuser     (tuser),
        .m_axis_tlast     (tlast),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .o_commit_pending (pending),
        .o_version        (version)
    );

    typedef struct packed {
        logic [63:0]     data;
        logic [CH_W-1:0] ch;
        logic            last;
    } beat_t;

    logic [31:0] m_sh_gain [NUM_CH];
    logic [31:0] m_sh_off  [NUM_CH];
    logic [31:0] m_act_gain[NUM_CH];
    logic [31:0] m_act_off [NUM_CH];
    logic [15:0] m_ver;
    logic        m_pend;
    logic [31:0] m_rd;
    beat_t       m_q[$];
    int          total = 0;
    int          bad = 0;
    int          dut_beats = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_q.size() > 0) return 2'd2;
        return m_pend ? 2'd1 : 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh_gain[i] = DG; m_sh_off[i] = DO;
            m_act_gain[i] = DG; m_act_off[i] = DO;
        end
        m_ver = 16'd0; m_pend = 1'b0; m_rd = 32'd0;
        m_q.delete();
        prev_valid = 1'b0;
    endtask

    // Applies one clock edge worth of spec rules, using the inputs driven before the edge.
    task automatic model_edge();
        int a;
        logic [31:0] rd;
        logic streaming;
        beat_t b;
        a = int'(rd_addr);
        if (a < NUM_CH)           rd = m_sh_gain[a];
        else if (a < 2*NUM_CH)    rd = m_sh_off[a-NUM_CH];
        else if (a == 2*NUM_CH)   rd = {m_ver, 13'b0, m_pend, m_state()};
        else                      rd = 32'd0;
        if (prev_valid && tready) dut_beats++;
        streaming = (m_q.size() > 0);
        if (streaming && tready) begin
            $display("beat ch=%0d data=%h last=%0d", m_q[0].ch, m_q[0].data, m_q[0].last);
            void'(m_q.pop_front());
        end
        if (!streaming && m_pend && frame_sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_act_gain[i] = m_sh_gain[i];
                m_act_off[i]  = m_sh_off[i];
                b.data = {m_sh_off[i], m_sh_gain[i]};
                b.ch   = CH_W'(i);
                b.last = (i == NUM_CH-1);
                m_q.push_back(b);
            end
            m_ver  = m_ver + 16'd1;
            m_pend = 1'b0;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (defaults) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_sh_gain[i] = DG; m_sh_off[i] = DO;
            end
        end
        if (wr_en) begin
            a = int'(wr_addr);
            if (a < NUM_CH)        m_sh_gain[a] = wr_data;
            else if (a < 2*NUM_CH) m_sh_off[a-NUM_CH] = wr_data;
        end
        m_rd = rd;
    endtask

    task automatic compare();
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("lane%0d", i), {offset[32*i +: 32], gain[32*i +: 32]},
                  {m_act_off[i], m_act_gain[i]});
        check("version", 64'(version), 64'(m_ver));
        check("pending", 64'(pending), 64'(m_pend));
        check("tvalid", 64'(tvalid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("tdata", tdata, m_q[0].data);
            check("tuser", 64'(tuser), 64'(m_q[0].ch));
            check("tlast", 64'(tlast), 64'(m_q[0].last));
        end
        check("rd_data", 64'(rd_data), 64'(m_rd));
        prev_valid = tvalid;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic clear_strobes();
        wr_en = 1'b0; commit = 1'b0; defaults = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic drain();
        tready = 1'b1;
        for (int k = 0; k < 40 && m_q.size() > 0; k++) step();
        check("drain_tvalid", 64'(tvalid), 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            check("rst_gain", 64'(gain[32*i +: 32]), 64'(DG));
            check("rst_off", 64'(offset[32*i +: 32]), 64'(DO));
        end
        check("rst_version", 64'(version), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_rd", 64'(rd_data), 64'd0);

        // gain[2] write, commit, frame_sync five cycles later
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h3F80_0000; step(); clear_strobes();
        commit = 1'b1; step(); clear_strobes();
        repeat (4) step();
        check("lane2_before", 64'(gain[64 +: 32]), 64'(DG));
        frame_sync = 1'b1; step(); clear_strobes();
        check("lane2_after", 64'(gain[64 +: 32]), 64'h3F80_0000);
        check("version1", 64'(version), 64'd1);
        dut_beats = 0;
        tready = 1'b1; step();
        check("beat1_tuser", 64'(tuser), 64'd1);
        tready = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h4000_0000; commit = 1'b1;
        step(); clear_strobes();
        check("stream_pend", 64'(pending), 64'd1);
        step(); step();
        check("hold_tuser", 64'(tuser), 64'd1);
        drain();
        check("beat_count", 64'(dut_beats), 64'd4);
        rd_addr = 4'd8; step();
        check("armed_status", 64'(rd_data), 64'h0001_0005);
        frame_sync = 1'b1; step(); clear_strobes();
        check("version2", 64'(version), 64'd2);
        check("lane3_commit2", 64'(gain[96 +: 32]), 64'h4000_0000);
        drain();

        // commit and frame_sync together in IDLE only arm the commit
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h1234_5678; step(); clear_strobes();
        commit = 1'b1; frame_sync = 1'b1; step(); clear_strobes();
        check("same_cycle_off0", 64'(offset[0 +: 32]), 64'(DO));
        repeat (3) step();
        frame_sync = 1'b1; step(); clear_strobes();
        check("late_apply_off0", 64'(offset[0 +: 32]), 64'h1234_5678);
        drain();

        // defaults reload with a concurrent write to offset[1]
        defaults = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0; step(); clear_strobes();
        for (int a = 0; a < 2*NUM_CH; a++) begin
            rd_addr = ADDR_W'(a); step();
        end
        rd_addr = 4'd5; step();
        check("rd_off1", 64'(rd_data), 64'd0);
        rd_addr = 4'd6; step();
        check("rd_off2", 64'(rd_data), 64'(DO));
        rd_addr = 4'd9; step();
        check("rd_addr9", 64'(rd_data), 64'd0);

        for (int n = 0; n < 1500; n++) begin
            wr_en      = ($urandom % 4) == 0;
            wr_addr    = ADDR_W'($urandom_range(0, 9));
            wr_data    = $urandom;
            rd_addr    = ADDR_W'($urandom_range(0, 10));
            defaults   = ($urandom % 40) == 0;
            commit     = ($urandom % 12) == 0;
            frame_sync = ($urandom % 8) == 0;
            tready     = ($urandom % 4) != 0;
            step();
        end
        clear_strobes();
        drain();

        // reset in the middle of a burst
        commit = 1'b1; step(); clear_strobes();
        frame_sync = 1'b1; step(); clear_strobes();
        tready = 1'b0; step();
        check("pre_rst_tvalid", 64'(tvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_version", 64'(version), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
